rand_word_sched: RTL and testbench

//  Round-robin scheduler sharing one single-bit LFSR random source among NREQ requesters.
//  A granted requester receives a WIDTH-bit random word assembled by stepping the LFSR once per cycle.
//  The word is handed over with a valid/ack handshake.

---
 rtl/rand_word_sched_if.sv | 39 +++
 rtl/rand_word_sched.sv | 141 ++++++++++++++
 tb/tb_rand_word_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_word_sched_if.sv
// ---------------------------------------------------------------------------
// rand_word_sched_if
//   Bundles the requester-side and LFSR-side signals of rand_word_sched.
//   Modport slave  : the scheduler itself.
//   Modport master : whatever drives requests, acks and the LFSR bit
//                    (requesters plus the LFSR instance, or a testbench).
//
//   req_i      NREQ   per-requester request level
//   ack_i      NREQ   per-requester acknowledge of the presented word
//   rand_i     1      random bit from the LFSR (pre-step value)
//   lfsr_en_o  1      LFSR step enable
//   grant_o    NREQ   one-hot owner of the current transaction
//   valid_o    NREQ   one-hot; data_o valid for that requester
//   data_o     WIDTH  random word, MSB = first bit sampled
//   busy_o     1      scheduler not idle
// ---------------------------------------------------------------------------
interface rand_word_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]  req_i;
    logic [NREQ-1:0]  ack_i;
    logic             rand_i;
    logic             lfsr_en_o;
    logic [NREQ-1:0]  grant_o;
    logic [NREQ-1:0]  valid_o;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;

    modport slave (
        input  req_i, ack_i, rand_i,
        output lfsr_en_o, grant_o, valid_o, data_o, busy_o
    );

    modport master (
        output req_i, ack_i, rand_i,
        input  lfsr_en_o, grant_o, valid_o, data_o, busy_o
    );
endinterface

// File: rtl/rand_word_sched.sv
// ---------------------------------------------------------------------------
// rand_word_sched
//   Round-robin scheduler sharing one single-bit LFSR among NREQ requesters.
//   The winner gets a WIDTH-bit word built by stepping the LFSR once per
//   cycle (GATHER), then the word is presented with valid/ack (PRESENT).
//
//   clk_i   clock
//   rst_i   asynchronous, active-low reset
//   bus     rand_word_sched_if.slave (req/ack/rand in; lfsr_en/grant/
//           valid/data/busy out)
// ---------------------------------------------------------------------------
module rand_word_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rand_word_sched_if.slave   bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATHER  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PTR_W-1:0] last_q,  last_d;
    logic [PTR_W-1:0] owner_q, owner_d;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand_idx;
    int               cand;

    // Round-robin pick: scan last+1, last+2, ... wrapping at NREQ (not at
    // 2**PTR_W), so a non-power-of-two NREQ never yields an out-of-range grant.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // the paths that skip an assignment infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_q) + i) % NREQ;
            cand_idx = PTR_W'(cand);
            if (!pick_found && bus.req_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    cnt_d             = '0;
                    data_d            = '0;
                    state_d           = GATHER;
                end
            end

            GATHER: begin
                // rand_i is the pre-step LFSR bit; the LFSR advances on this
                // same edge because lfsr_en_o is high throughout GATHER.
                data_d = {data_q[WIDTH-2:0], bus.rand_i};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    valid_d = grant_q;
                    state_d = PRESENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PRESENT: begin
                // Only the owner's ack counts; others are ignored.
                if (|(bus.ack_i & grant_q)) begin
                    valid_d = '0;
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= PTR_W'(NREQ - 1);
            owner_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // Decoded straight from state so both drop the instant reset asserts.
    assign bus.lfsr_en_o = (state_q == GATHER);
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.grant_o   = grant_q;
    assign bus.valid_o   = valid_q;
    assign bus.data_o    = data_q;

endmodule

// File: tb/tb_rand_word_sched.sv
// ---------------------------------------------------------------------------
// tb_rand_word_sched
//   Directed bench for rand_word_sched (NREQ=4, WIDTH=8). A stub LFSR
//   produces 1,0,1,0,... advancing once per lfsr_en_o cycle, or a constant 1.
// ---------------------------------------------------------------------------
module tb_rand_word_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    rand_word_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    rand_word_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // LFSR stub: toggles on each stepped edge, restartable at 1.
    logic rand_q;
    logic stub_clear;
    logic hold_one;
    always @(posedge clk) begin
        if (stub_clear)         rand_q <= 1'b1;
        else if (bus.lfsr_en_o) rand_q <= ~rand_q;
    end
    assign bus.rand_i = hold_one ? 1'b1 : rand_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i      = 1'b0;
        bus.req_i  = '0;
        bus.ack_i  = '0;
        stub_clear = 1'b1;
        repeat (2) @(negedge clk);
        rst_i      = 1'b1;
        stub_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_stub();
        stub_clear = 1'b1;
        @(negedge clk);
        stub_clear = 1'b0;
    endtask

    // Waits for grant_o to fall to zero (if set) and then rise again.
    task automatic wait_grant(output logic [NREQ-1:0] g);
        for (int i = 0; i < 40 && bus.grant_o != '0; i++) @(negedge clk);
        for (int i = 0; i < 40 && bus.grant_o == '0; i++) @(negedge clk);
        g = bus.grant_o;
    endtask

    // Counts lfsr_en_o cycles until valid_o rises (bounded).
    task automatic count_gather(output int n);
        n = 0;
        for (int i = 0; i < 40 && bus.valid_o == '0; i++) begin
            if (bus.lfsr_en_o) n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && bus.busy_o; i++) @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && bus.valid_o == '0; i++) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] grants [6];
        int              gcyc   [6];
        logic [NREQ-1:0] exp_order [6];
        int              n, ng, en_cnt;
        logic            ok, seen;

        rst_i      = 1'b0;
        bus.req_i  = '0;
        bus.ack_i  = '0;
        stub_clear = 1'b1;
        hold_one   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_grant",   32'(bus.grant_o),   0);
        check("rst_valid",   32'(bus.valid_o),   0);
        check("rst_data",    32'(bus.data_o),    0);
        check("rst_busy",    32'(bus.busy_o),    0);
        check("rst_lfsr_en", 32'(bus.lfsr_en_o), 0);
        rst_i      = 1'b1;
        stub_clear = 1'b0;
        @(negedge clk);

        // 1: single request, 8-cycle gather, word 0xAA, held until ack
        bus.req_i = 4'b0001;
        @(negedge clk);
        check("t1_grant", 32'(bus.grant_o), 32'h1);
        bus.req_i = '0;
        count_gather(n);
        check("t1_en_cycles", 32'(n), 8);
        check("t1_valid", 32'(bus.valid_o), 32'h1);
        check("t1_data",  32'(bus.data_o),  32'hAA);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.data_o !== 8'hAA || bus.valid_o !== 4'b0001) ok = 1'b0;
        end
        check("t1_hold_stable", 32'(ok), 1);
        bus.ack_i = 4'b0001;
        @(negedge clk);
        check("t1_valid_drop", 32'(bus.valid_o), 0);
        check("t1_busy_drop",  32'(bus.busy_o),  0);
        bus.ack_i = '0;

        // 2: all requesting, ack tied high -> 0,1,2,3,0,1 every 10 cycles
        do_reset();
        bus.req_i = 4'b1111;
        bus.ack_i = 4'b1111;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        ng = 0;
        en_cnt = 0;
        prev = '0;
        for (int cyc = 0; cyc < 80 && ng < 6; cyc++) begin
            if (bus.grant_o != '0 && prev == '0) begin
                grants[ng] = bus.grant_o;
                gcyc[ng]   = cyc;
                ng++;
            end
            if (ng >= 1 && cyc < gcyc[0] + 10 && bus.lfsr_en_o) en_cnt++;
            prev = bus.grant_o;
            @(negedge clk);
        end
        check("t2_ngrants", 32'(ng), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ng) check($sformatf("t2_order%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end
        for (int i = 1; i < 6; i++) begin
            if (i < ng) check($sformatf("t2_period%0d", i), 32'(gcyc[i] - gcyc[i-1]), 10);
        end
        check("t2_en_duty", 32'(en_cnt), 8);
        bus.req_i = '0;
        wait_idle();
        check("t2_idle", 32'(bus.busy_o), 0);
        bus.ack_i = '0;

        // 3: last=0, req 1001 -> grant 3, then 0
        do_reset();
        bus.req_i = 4'b0001;
        bus.ack_i = 4'b1111;
        wait_grant(g);
        check("t3_first", 32'(g), 32'h1);
        bus.req_i = 4'b1001;
        wait_grant(g);
        check("t3_grant3", 32'(g), 32'h8);
        wait_grant(g);
        check("t3_grant0", 32'(g), 32'h1);
        bus.req_i = '0;
        wait_idle();
        bus.ack_i = '0;

        // 4: ack from non-owners ignored in PRESENT
        do_reset();
        bus.req_i = 4'b0100;
        wait_grant(g);
        check("t4_grant", 32'(g), 32'h4);
        bus.req_i = '0;
        wait_valid();
        check("t4_valid", 32'(bus.valid_o), 32'h4);
        bus.ack_i = 4'b1011;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.valid_o !== 4'b0100 || !bus.busy_o) ok = 1'b0;
        end
        check("t4_foreign_ack_ignored", 32'(ok), 1);
        bus.ack_i = 4'b1111;
        @(negedge clk);
        check("t4_valid_drop", 32'(bus.valid_o), 0);
        check("t4_busy_drop",  32'(bus.busy_o),  0);
        bus.ack_i = '0;

        // 5: reset in GATHER cycle 3 drops everything immediately
        do_reset();
        bus.req_i = 4'b0001;
        wait_grant(g);
        bus.req_i = '0;
        repeat (2) @(negedge clk);
        check("t5_gathering", 32'(bus.lfsr_en_o), 1);
        #2 rst_i = 1'b0;
        #1;
        check("t5_rst_en",    32'(bus.lfsr_en_o), 0);
        check("t5_rst_busy",  32'(bus.busy_o),    0);
        check("t5_rst_grant", 32'(bus.grant_o),   0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.valid_o != '0) seen = 1'b1;
        end
        check("t5_no_valid", 32'(seen), 0);
        clear_stub();
        bus.req_i = 4'b0010;
        @(negedge clk);
        check("t5_grant", 32'(bus.grant_o), 32'h2);
        bus.req_i = '0;
        count_gather(n);
        check("t5_en_cycles", 32'(n), 8);
        check("t5_valid", 32'(bus.valid_o), 32'h2);
        check("t5_data",  32'(bus.data_o),  32'hAA);
        bus.ack_i = 4'b0010;
        @(negedge clk);
        check("t5_valid_drop", 32'(bus.valid_o), 0);
        bus.ack_i = '0;

        // 6: rand held 1, one-cycle request pulse still completes
        hold_one = 1'b1;
        @(negedge clk);
        bus.req_i = 4'b0001;
        @(negedge clk);
        bus.req_i = '0;
        wait_valid();
        check("t6_valid", 32'(bus.valid_o), 32'h1);
        check("t6_data",  32'(bus.data_o),  32'hFF);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.valid_o !== 4'b0001 || bus.data_o !== 8'hFF) ok = 1'b0;
        end
        check("t6_hold", 32'(ok), 1);
        bus.ack_i = 4'b0001;
        @(negedge clk);
        check("t6_valid_drop", 32'(bus.valid_o), 0);
        bus.ack_i = '0;
        hold_one  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
